// File: rtl/rv32i_types.sv
// Shared types for the branch predictor: 2-bit counter states and the PHT init FSM states.
package rv32i_types;

    typedef enum logic [1:0] {
        CtrSnt = 2'b00,
        CtrWnt = 2'b01,
        CtrWt  = 2'b10,
        CtrSt  = 2'b11
    } ctr_t;

    typedef enum logic [0:0] {
        StInit = 1'b0,
        StRun  = 1'b1
    } gshare_state_t;

endpackage

// File: rtl/sat_counter2.sv
// 2-bit saturating counter next-state: count up on taken, down otherwise, clamp at SNT/ST.
module sat_counter2
    import rv32i_types::*;
(
    input  ctr_t i_state,
    input  logic i_taken,
    output ctr_t o_next
);

    always_comb begin
        o_next = i_state;
        unique case (i_state)
            CtrSnt: o_next = i_taken ? CtrWnt : CtrSnt;
            CtrWnt: o_next = i_taken ? CtrWt  : CtrSnt;
            CtrWt:  o_next = i_taken ? CtrSt  : CtrWnt;
            CtrSt:  o_next = i_taken ? CtrSt  : CtrWt;
            default: o_next = i_state;
        endcase
    end

endmodule

// File: rtl/gshare_pred.sv
// Gshare direction predictor with speculative global history and a walked PHT initialisation.
// Define GSHARE_PERF_CNT_EN to build the prediction/mispredict performance counters.
module gshare_pred
    import rv32i_types::*;
#(
    parameter int unsigned HIST_LEN = 3,
    parameter int unsigned IDX_W    = 3,
    parameter int unsigned PC_LSB   = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                fetch_valid,
    input  logic [31:0]         fetch_pc,
    output logic                pred_valid,
    output logic                pred_taken,
    output logic [HIST_LEN-1:0] pred_hist,
    input  logic                upd_valid,
    input  logic [31:0]         upd_pc,
    input  logic [HIST_LEN-1:0] upd_hist,
    input  logic                upd_taken,
    input  logic                upd_mispredict,
    output logic                ready,
    output logic [31:0]         perf_pred_cnt,
    output logic [31:0]         perf_mispred_cnt
);

    localparam int unsigned Depth = 2 ** IDX_W;

    gshare_state_t       r_state, w_state_next;
    logic [IDX_W-1:0]    r_init_cnt, w_init_cnt_next;
    logic [HIST_LEN-1:0] r_spec_ghr, w_spec_ghr_next;
    logic                r_pred_valid, r_pred_taken;
    logic [HIST_LEN-1:0] r_pred_hist;
    ctr_t                r_pht [Depth];

    logic [IDX_W-1:0]    w_fetch_hx, w_upd_hx, w_fetch_idx, w_upd_idx, w_pht_widx;
    logic                w_fetch_acc, w_upd_acc, w_pred_bit, w_pht_we;
    ctr_t                w_fetch_ctr, w_upd_ctr, w_ctr_next, w_pht_wdata;
    logic                w_unused;

    // Fold history onto the index width: truncate if longer, zero-extend if shorter.
    if (HIST_LEN >= IDX_W) begin : g_hist_trunc
        assign w_fetch_hx = r_spec_ghr[IDX_W-1:0];
        assign w_upd_hx   = upd_hist[IDX_W-1:0];
    end else begin : g_hist_zext
        assign w_fetch_hx = {{(IDX_W - HIST_LEN){1'b0}}, r_spec_ghr};
        assign w_upd_hx   = {{(IDX_W - HIST_LEN){1'b0}}, upd_hist};
    end

    assign w_unused    = ^{fetch_pc, upd_pc, upd_hist};
    assign ready       = (r_state == StRun);
    assign w_fetch_acc = fetch_valid & ready;
    assign w_upd_acc   = upd_valid & ready;
    assign w_fetch_idx = fetch_pc[PC_LSB +: IDX_W] ^ w_fetch_hx;
    assign w_upd_idx   = upd_pc[PC_LSB +: IDX_W] ^ w_upd_hx;
    assign w_fetch_ctr = r_pht[w_fetch_idx];
    assign w_upd_ctr   = r_pht[w_upd_idx];
    assign w_pred_bit  = w_fetch_ctr[1];

    sat_counter2 u_sat_counter2 (
        .i_state (w_upd_ctr),
        .i_taken (upd_taken),
        .o_next  (w_ctr_next)
    );

    always_comb begin
        w_state_next    = r_state;
        w_init_cnt_next = r_init_cnt;
        unique case (r_state)
            StInit: begin
                w_init_cnt_next = r_init_cnt + 1'b1;
                if (&r_init_cnt) w_state_next = StRun;
            end
            StRun:   w_state_next = StRun;
            default: w_state_next = StInit;
        endcase
    end

    // A mispredict repair wins over the speculative shift of a same-cycle fetch.
    always_comb begin
        w_spec_ghr_next = r_spec_ghr;
        if (w_upd_acc && upd_mispredict) begin
            w_spec_ghr_next = {upd_hist[HIST_LEN-2:0], upd_taken};
        end else if (w_fetch_acc) begin
            w_spec_ghr_next = {r_spec_ghr[HIST_LEN-2:0], w_pred_bit};
        end
    end

    always_comb begin
        w_pht_we    = w_upd_acc;
        w_pht_widx  = w_upd_idx;
        w_pht_wdata = w_ctr_next;
        if (r_state == StInit) begin
            w_pht_we    = 1'b1;
            w_pht_widx  = r_init_cnt;
            w_pht_wdata = CtrWnt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= StInit;
            r_init_cnt   <= '0;
            r_spec_ghr   <= '0;
            r_pred_valid <= 1'b0;
            r_pred_taken <= 1'b0;
            r_pred_hist  <= '0;
        end else begin
            r_state      <= w_state_next;
            r_init_cnt   <= w_init_cnt_next;
            r_spec_ghr   <= w_spec_ghr_next;
            r_pred_valid <= w_fetch_acc;
            if (w_fetch_acc) begin
                r_pred_taken <= w_pred_bit;
                r_pred_hist  <= r_spec_ghr;
            end
        end
    end

    // No reset on the table; INIT rewrites every entry instead.
    always_ff @(posedge clk) begin
        if (w_pht_we) r_pht[w_pht_widx] <= w_pht_wdata;
    end

    assign pred_valid = r_pred_valid;
    assign pred_taken = r_pred_taken;
    assign pred_hist  = r_pred_hist;

`ifdef GSHARE_PERF_CNT_EN
    logic [31:0] r_perf_pred, r_perf_mis;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf_pred <= '0;
            r_perf_mis  <= '0;
        end else begin
            if (r_pred_valid && !(&r_perf_pred)) r_perf_pred <= r_perf_pred + 32'd1;
            if (w_upd_acc && upd_mispredict && !(&r_perf_mis)) r_perf_mis <= r_perf_mis + 32'd1;
        end
    end

    assign perf_pred_cnt    = r_perf_pred;
    assign perf_mispred_cnt = r_perf_mis;
`else
    assign perf_pred_cnt    = '0;
    assign perf_mispred_cnt = '0;
`endif

endmodule

// File: tb/tb_gshare_pred.sv
// Directed self-checking bench for gshare_pred at default parameters.
module tb_gshare_pred;

    logic        clk;
    logic        rst_n;
    logic        fetch_valid;
    logic [31:0] fetch_pc;
    logic        pred_valid;
    logic        pred_taken;
    logic [2:0]  pred_hist;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic [2:0]  upd_hist;
    logic        upd_taken;
    logic        upd_mispredict;
    logic        ready;
    logic [31:0] perf_pred_cnt;
    logic [31:0] perf_mispred_cnt;

    int n_vec;
    int n_err;

`ifdef GSHARE_PERF_CNT_EN
    localparam logic [31:0] ExpPred = 32'd10;
    localparam logic [31:0] ExpMis  = 32'd3;
`else
    localparam logic [31:0] ExpPred = 32'd0;
    localparam logic [31:0] ExpMis  = 32'd0;
`endif

    gshare_pred dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .fetch_valid      (fetch_valid),
        .fetch_pc         (fetch_pc),
        .pred_valid       (pred_valid),
        .pred_taken       (pred_taken),
        .pred_hist        (pred_hist),
        .upd_valid        (upd_valid),
        .upd_pc           (upd_pc),
        .upd_hist         (upd_hist),
        .upd_taken        (upd_taken),
        .upd_mispredict   (upd_mispredict),
        .ready            (ready),
        .perf_pred_cnt    (perf_pred_cnt),
        .perf_mispred_cnt (perf_mispred_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_fetch(input logic v, input logic [31:0] pc);
        fetch_valid = v;
        fetch_pc    = pc;
    endtask

    task automatic set_upd(input logic v, input logic [31:0] pc, input logic [2:0] h,
                           input logic t, input logic m);
        upd_valid      = v;
        upd_pc         = pc;
        upd_hist       = h;
        upd_taken      = t;
        upd_mispredict = m;
    endtask

    task automatic check_pred(input string tag, input logic t, input logic [2:0] h);
        check({tag, "_valid"}, {31'd0, pred_valid}, 32'd1);
        check({tag, "_taken"}, {31'd0, pred_taken}, {31'd0, t});
        check({tag, "_hist"}, {29'd0, pred_hist}, {29'd0, h});
    endtask

    // Counts edges after reset release; ready must appear on exactly the 8th.
    task automatic init_walk(input string tag);
        for (int i = 1; i <= 7; i++) begin
            tick();
            check({tag, "_ready_lo"}, {31'd0, ready}, 32'd0);
            check({tag, "_pv_lo"}, {31'd0, pred_valid}, 32'd0);
        end
        tick();
        check({tag, "_ready_hi"}, {31'd0, ready}, 32'd1);
        check({tag, "_pv_lo8"}, {31'd0, pred_valid}, 32'd0);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        set_fetch(1'b0, 32'd0);
        set_upd(1'b0, 32'd0, 3'd0, 1'b0, 1'b0);
        #12;
        check("rst_ready", {31'd0, ready}, 32'd0);
        check("rst_pv", {31'd0, pred_valid}, 32'd0);
        check("rst_pt", {31'd0, pred_taken}, 32'd0);
        check("rst_ph", {29'd0, pred_hist}, 32'd0);
        check("rst_perf_p", perf_pred_cnt, 32'd0);
        check("rst_perf_m", perf_mispred_cnt, 32'd0);

        // Requests during INIT must be ignored.
        tick();
        rst_n = 1'b1;
        set_fetch(1'b1, 32'h10);
        set_upd(1'b1, 32'h10, 3'b111, 1'b1, 1'b1);
        init_walk("init");
        set_fetch(1'b0, 32'd0);
        set_upd(1'b0, 32'd0, 3'd0, 1'b0, 1'b0);

        set_fetch(1'b1, 32'h40);
        tick();
        check_pred("first", 1'b0, 3'b000);
        set_fetch(1'b0, 32'd0);
        tick();
        check("idle_pv", {31'd0, pred_valid}, 32'd0);

        // Entry 4: 01 -> 10 -> 11 -> 11.
        set_upd(1'b1, 32'h10, 3'b000, 1'b1, 1'b0);
        tick();
        tick();
        tick();
        set_upd(1'b0, 32'd0, 3'd0, 1'b0, 1'b0);
        set_fetch(1'b1, 32'h10);
        tick();
        check_pred("sat_st", 1'b1, 3'b000);
        set_fetch(1'b0, 32'd0);

        // Mispredict repair to history 000 (entry 7 -> 00).
        set_upd(1'b1, 32'h1C, 3'b000, 1'b0, 1'b1);
        tick();
        set_upd(1'b0, 32'd0, 3'd0, 1'b0, 1'b0);

        // Predict 1,0,1 back to back.
        set_fetch(1'b1, 32'h10);
        tick();
        check_pred("seq0", 1'b1, 3'b000);
        set_fetch(1'b1, 32'h00);
        tick();
        check_pred("seq1", 1'b0, 3'b001);
        set_fetch(1'b1, 32'h18);
        tick();
        check_pred("seq2", 1'b1, 3'b010);

        // Same-cycle fetch and mispredict: repair {11,0} wins over the shift.
        set_fetch(1'b1, 32'h00);
        set_upd(1'b1, 32'h00, 3'b011, 1'b0, 1'b1);
        tick();
        check_pred("ghr101", 1'b0, 3'b101);
        set_upd(1'b0, 32'd0, 3'd0, 1'b0, 1'b0);
        tick();
        check_pred("repair110", 1'b0, 3'b110);

        // Same-cycle read/write of entry 4 returns the old counter.
        set_upd(1'b1, 32'h10, 3'b000, 1'b0, 1'b1);
        tick();
        check_pred("nobyp_st", 1'b1, 3'b100);
        set_fetch(1'b1, 32'h10);
        set_upd(1'b1, 32'h10, 3'b000, 1'b0, 1'b0);
        tick();
        check_pred("nobyp_wt", 1'b1, 3'b000);
        set_upd(1'b0, 32'd0, 3'd0, 1'b0, 1'b0);
        set_fetch(1'b1, 32'h14);
        tick();
        check_pred("after_dec", 1'b0, 3'b001);
        set_fetch(1'b0, 32'd0);
        tick();
        tick();
        check("perf_pred", perf_pred_cnt, ExpPred);
        check("perf_mis", perf_mispred_cnt, ExpMis);

        // Push entry 4 back to 11 so a missed re-init would show as taken.
        set_upd(1'b1, 32'h10, 3'b000, 1'b1, 1'b0);
        tick();
        tick();
        set_upd(1'b0, 32'd0, 3'd0, 1'b0, 1'b0);

        rst_n = 1'b0;
        #1;
        check("rst2_ready", {31'd0, ready}, 32'd0);
        check("rst2_perf_p", perf_pred_cnt, 32'd0);
        check("rst2_perf_m", perf_mispred_cnt, 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        check("mid_init_ready", {31'd0, ready}, 32'd0);
        rst_n = 1'b0;
        #1;
        check("rst3_ready", {31'd0, ready}, 32'd0);
        rst_n = 1'b1;
        init_walk("reinit");
        set_fetch(1'b1, 32'h10);
        tick();
        check_pred("reinit_pred", 1'b0, 3'b000);
        set_fetch(1'b0, 32'd0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
